// File: rtl/connector_bist_ctrl.sv
// BIST sequencer for the Connector datapath: LFSR pattern source, latency-aligned MISR compaction, golden compare.
// Optional abort input/aborted output enabled by defining CONN_BIST_ABORT_EN.
module connector_bist_ctrl #(
  parameter int          NUM_PATTERNS = 63,
  parameter int          LATENCY      = 1,
  parameter logic [5:0]  SEED         = 6'h01,
  parameter logic [4:0]  GOLDEN_SIG   = 5'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] pat_out,
  input  logic [4:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] signature
`ifdef CONN_BIST_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  localparam int PW = (LATENCY == 0) ? 1 : LATENCY;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [5:0]      lfsr;
  logic [5:0]      cnt;
  logic [PW-1:0]   pipe;
  logic            cap;
  logic            abort_hit;
  logic [4:0]      misr_nxt;

  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4]};
  endfunction

  function automatic logic [4:0] misr_step(input logic [4:0] sig, input logic [4:0] d);
    return ({sig[3:0], 1'b0} ^ (sig[4] ? 5'b00101 : 5'b00000)) ^ d;
  endfunction

  // With zero latency the response belongs to the pattern on the bus this same cycle.
  always_comb begin
    cap      = (LATENCY == 0) ? (state == RUN) : pipe[PW-1];
    misr_nxt = cap ? misr_step(signature, dut_out) : signature;
  end

`ifdef CONN_BIST_ABORT_EN
  assign abort_hit = abort && ((state == RUN) || (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr      <= '0;
      cnt       <= '0;
      pipe      <= '0;
      pat_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
`ifdef CONN_BIST_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
`ifdef CONN_BIST_ABORT_EN
      aborted <= 1'b0;
`endif
      pipe <= (pipe << 1) | PW'(state == RUN);
      if (abort_hit) begin
        // Partial signature is frozen; pending captures are discarded.
        state   <= IDLE;
        pipe    <= '0;
        pat_out <= '0;
        busy    <= 1'b0;
        done    <= 1'b0;
        pass    <= 1'b0;
`ifdef CONN_BIST_ABORT_EN
        aborted <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= RUN;
              pat_out   <= SEED;
              lfsr      <= lfsr_step(SEED);
              cnt       <= '0;
              pipe      <= '0;
              busy      <= 1'b1;
              done      <= 1'b0;
              pass      <= 1'b0;
              signature <= '0;
            end
          end
          RUN: begin
            signature <= misr_nxt;
            lfsr      <= lfsr_step(lfsr);
            pat_out   <= lfsr;
            cnt       <= cnt + 6'd1;
            if (cnt == 6'(NUM_PATTERNS - 1)) begin
              pat_out <= '0;
              cnt     <= '0;
              if (LATENCY == 0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (misr_nxt == GOLDEN_SIG);
              end else begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            signature <= misr_nxt;
            cnt       <= cnt + 6'd1;
            if (cnt == 6'(LATENCY - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (misr_nxt == GOLDEN_SIG);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
